// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: AHB-lite slave that owns the FIR coefficient set.
// Software fills a shadow bank; a SWAP request copies shadow to the active
// bank (which drives fircoefs) once the FIR reports it is not busy.
// Build macro FIR_COEF_SYM_EN: a shadow write to index i also writes index
// TAPS-1-i, and writes to the upper half of the index range are rejected.
//
// Handshake: an address phase is accepted when hready & hsel & htrans[1];
// its data phase completes on the first cycle with hreadyout=1 (hwdata is
// sampled then). Shadow writes hold hreadyout low while a swap is pending
// or in progress. Errors answer hreadyout/hresp = 0/1, then 1/1.
module fir_coef_ctrl #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int BIT_PREC = 16,
    parameter int TAPS     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hsel,
    input  logic [AWIDTH-1:0]          haddr,
    input  logic [2:0]                 hsize,
    input  logic                       hwrite,
    input  logic [1:0]                 htrans,
    input  logic [DWIDTH-1:0]          hwdata,
    input  logic                       hready,
    output logic                       hreadyout,
    output logic                       hresp,
    output logic [DWIDTH-1:0]          hrdata,
    input  logic                       fir_busy,
    output logic signed [BIT_PREC-1:0] fircoefs [0:TAPS-1],
    output logic                       coef_update
);

    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t                     state_q;
    logic signed [BIT_PREC-1:0] shadow_q [0:TAPS-1];
    logic signed [BIT_PREC-1:0] active_q [0:TAPS-1];
    logic [7:0]                 wcnt_q;
    logic                       coef_update_q;

    // Data-phase context captured from the address phase
    logic          dp_valid_q;
    logic          dp_write_q;
    logic          dp_ctrl_q;
    logic          dp_stat_q;
    logic          dp_coef_q;
    logic [IW-1:0] dp_idx_q;
    logic          err1_q;
    logic          err2_q;

    // Address-phase decode
    logic [9:0] a_off;
    logic [7:0] a_idx8;
    logic       a_sel;
    logic       a_is_ctrl;
    logic       a_is_stat;
    logic       a_is_coef;
    logic       a_err;

    assign a_off     = haddr[9:0];
    assign a_idx8    = {2'b00, a_off[7:2]};
    assign a_sel     = hready & hsel & htrans[1];
    assign a_is_ctrl = (a_off == 10'h000);
    assign a_is_stat = (a_off == 10'h004);
    assign a_is_coef = (a_off[9:8] == 2'b01) && (a_off[1:0] == 2'b00) &&
                       (a_idx8 < 8'(TAPS));
`ifdef FIR_COEF_SYM_EN
    assign a_err = (hsize != 3'b010) || !(a_is_ctrl || a_is_stat || a_is_coef) ||
                   (hwrite && a_is_coef && (a_idx8 >= 8'((TAPS + 1) / 2)));
`else
    assign a_err = (hsize != 3'b010) || !(a_is_ctrl || a_is_stat || a_is_coef);
`endif

    // Data-phase actions
    logic stall;
    logic wr_coef;
    logic wr_ctrl;
    logic ctrl_clr;
    logic ctrl_swap;

    assign stall     = dp_valid_q & dp_write_q & dp_coef_q & (state_q != ST_IDLE);
    assign wr_coef   = dp_valid_q & dp_write_q & dp_coef_q & ~stall;
    assign wr_ctrl   = dp_valid_q & dp_write_q & dp_ctrl_q;
    assign ctrl_clr  = wr_ctrl & hwdata[1];
    assign ctrl_swap = wr_ctrl & hwdata[0];

    assign hreadyout   = ~err1_q & ~stall;
    assign hresp       = err1_q | err2_q;
    assign coef_update = coef_update_q;
    assign fircoefs    = active_q;

    // Address bits above the decoded window and the unused half of hwdata
    logic unused_bits;
    assign unused_bits = ^{haddr[AWIDTH-1:10], htrans[0], hwdata[DWIDTH-1:BIT_PREC]};

    // Capture address phase; illegal accesses start the two-cycle error reply
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_ctrl_q  <= 1'b0;
            dp_stat_q  <= 1'b0;
            dp_coef_q  <= 1'b0;
            dp_idx_q   <= '0;
            err1_q     <= 1'b0;
            err2_q     <= 1'b0;
        end else begin
            err2_q <= err1_q;
            err1_q <= hready & a_sel & a_err;
            if (hready) begin
                dp_valid_q <= a_sel & ~a_err;
                dp_write_q <= hwrite;
                dp_ctrl_q  <= a_is_ctrl;
                dp_stat_q  <= a_is_stat;
                dp_coef_q  <= a_is_coef;
                dp_idx_q   <= a_off[IW+1:2];
            end
        end
    end

`ifdef FIR_COEF_SYM_EN
    logic [IW-1:0] mir_idx;
    assign mir_idx = IW'(TAPS - 1) - dp_idx_q;
`endif

    // Shadow bank and saturating write counter; CLR wins over everything
    always_ff @(posedge clk) begin
        if (rst || ctrl_clr) begin
            for (int i = 0; i < TAPS; i++) shadow_q[i] <= '0;
            wcnt_q <= 8'd0;
        end else if (wr_coef) begin
            shadow_q[dp_idx_q] <= hwdata[BIT_PREC-1:0];
`ifdef FIR_COEF_SYM_EN
            shadow_q[mir_idx] <= hwdata[BIT_PREC-1:0];
`endif
            if (wcnt_q != 8'hFF) wcnt_q <= wcnt_q + 8'd1;
        end
    end

    // Swap FSM: copy shadow to active on entry to SWAP, pulse coef_update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            coef_update_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) active_q[i] <= '0;
        end else begin
            coef_update_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_swap) state_q <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (!fir_busy) begin
                        state_q       <= ST_SWAP;
                        coef_update_q <= 1'b1;
                        for (int i = 0; i < TAPS; i++) active_q[i] <= shadow_q[i];
                    end
                end
                ST_SWAP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read mux for the current data phase (reflects pre-edge state)
    always_comb begin
        hrdata = '0;
        if (dp_valid_q && !dp_write_q) begin
            if (dp_stat_q) begin
                hrdata[15:8] = wcnt_q;
                hrdata[0]    = (state_q == ST_PENDING);
            end else if (dp_coef_q) begin
                hrdata = DWIDTH'(shadow_q[dp_idx_q]);
            end
        end
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Testbench for fir_coef_ctrl: directed sequence with randomized data,
// checked against a bank/counter model kept here.
module tb_fir_coef_ctrl;

  localparam int TAPS = 16;
`ifdef FIR_COEF_SYM_EN
  localparam int WRITABLE = (TAPS + 1) / 2;
`else
  localparam int WRITABLE = TAPS;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               hsel = 1'b0;
  logic [31:0]        haddr = '0;
  logic [2:0]         hsize = 3'b010;
  logic               hwrite = 1'b0;
  logic [1:0]         htrans = 2'b00;
  logic [31:0]        hwdata = '0;
  logic               hready;
  logic               hreadyout;
  logic               hresp;
  logic [31:0]        hrdata;
  logic               fir_busy = 1'b0;
  logic signed [15:0] fircoefs [0:TAPS-1];
  logic               coef_update;

  assign hready = hreadyout;

  fir_coef_ctrl #(.AWIDTH(32), .DWIDTH(32), .BIT_PREC(16), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hsize(hsize),
    .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .fir_busy(fir_busy), .fircoefs(fircoefs), .coef_update(coef_update)
  );

  // reference model
  logic [15:0] m_sh [TAPS];
  logic [15:0] m_act [TAPS];
  int          m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] status_exp(input logic pend);
    return {16'h0, 8'(m_cnt), 7'h0, pend};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) m_sh[i] = '0;
    m_cnt = 0;
  endtask

  task automatic model_swap();
    for (int i = 0; i < TAPS; i++) m_act[i] = m_sh[i];
  endtask

  task automatic model_write(input int idx, input logic [15:0] v);
    m_sh[idx] = v;
`ifdef FIR_COEF_SYM_EN
    m_sh[TAPS-1-idx] = v;
`endif
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic check_active(input string tag);
    for (int i = 0; i < TAPS; i++)
      check($sformatf("%s_act%0d", tag, i), {16'h0, fircoefs[i]}, {16'h0, m_act[i]});
  endtask

  // driver tasks: entered and left at #1 after a rising edge
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    int waits;
    hsel = 1'b1; haddr = addr; hwrite = 1'b1; htrans = 2'b10; hsize = 3'b010;
    step();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
    waits = 0;
    while (hreadyout !== 1'b1 && waits < 100) begin
      step();
      waits++;
    end
    if (waits >= 100) begin
      n_cmp++; n_bad++;
      $error("FAIL wr_timeout addr=%h observed=stuck expected=ready", addr);
    end
    step();
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    hsel = 1'b1; haddr = addr; hwrite = 1'b0; htrans = 2'b10; hsize = 3'b010;
    step();
    hsel = 1'b0; htrans = 2'b00;
    check({tag, "_rdy"}, {31'h0, hreadyout}, 32'h1);
    check(tag, hrdata, exp);
    step();
  endtask

  task automatic ahb_err(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input string tag);
    hsel = 1'b1; haddr = addr; hwrite = wr; htrans = 2'b10; hsize = size;
    step();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = $urandom;
    check({tag, "_c1"}, {30'h0, hreadyout, hresp}, 32'h1);
    step();
    check({tag, "_c2"}, {30'h0, hreadyout, hresp}, 32'h3);
    step();
    check({tag, "_c3"}, {30'h0, hreadyout, hresp}, 32'h2);
  endtask

  task automatic coef_write(input int idx, input logic [15:0] v);
    if (idx >= WRITABLE) begin
      ahb_err(32'h100 + 32'(4 * idx), 1'b1, 3'b010, $sformatf("sym_err%0d", idx));
    end else begin
      ahb_write(32'h100 + 32'(4 * idx), {16'h0, v});
      model_write(idx, v);
    end
  endtask

  initial begin
    logic [15:0] v;
    int          idx;

    // reset
    model_clear();
    for (int i = 0; i < TAPS; i++) m_act[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
    check("rst_hresp", {31'h0, hresp}, 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_coef_update", {31'h0, coef_update}, 32'h0);
    check_active("rst");
    read_check(32'h004, 32'h0, "rst_status");
    for (int i = 0; i < TAPS; i++) read_check(32'h100 + 32'(4 * i), 32'h0, $sformatf("rst_sh%0d", i));

    // fill 1..TAPS, swap with FIR idle: pulse two cycles after the data phase
    for (int i = 0; i < TAPS; i++) coef_write(i, 16'(i + 1));
    read_check(32'h004, status_exp(1'b0), "fill_status");
    read_check(32'h000, 32'h0, "ctrl_reads_zero");
    ahb_write(32'h000, 32'h1);
    check("swap_lat1_upd", {31'h0, coef_update}, 32'h0);
    check_active("swap_lat1");
    step();
    check("swap_lat2_upd", {31'h0, coef_update}, 32'h1);
    model_swap();
    check_active("swap_lat2");
    step();
    check("swap_after_upd", {31'h0, coef_update}, 32'h0);

    // random update, swap held off by fir_busy
    for (int k = 0; k < 4; k++) coef_write(int'($urandom_range(0, WRITABLE - 1)), 16'($urandom));
    fir_busy = 1'b1;
    ahb_write(32'h000, 32'h1);
    for (int k = 0; k < 10; k++) begin
      read_check(32'h004, status_exp(1'b1), "busy_status");
      check("busy_upd", {31'h0, coef_update}, 32'h0);
      check("busy_act0", {16'h0, fircoefs[0]}, {16'h0, m_act[0]});
    end
    ahb_write(32'h000, 32'h1);  // SWAP while pending: ignored, no error
    check("dup_swap_hresp", {31'h0, hresp}, 32'h0);
    check_active("busy_end");
    fir_busy = 1'b0;
    step();
    check("busy_drop_upd", {31'h0, coef_update}, 32'h1);
    model_swap();
    check_active("busy_drop");
    step();
    check("busy_drop_after", {31'h0, coef_update}, 32'h0);
    read_check(32'h004, status_exp(1'b0), "busy_status_done");

    // shadow write while pending waits until the swap is done
    coef_write(3, 16'($urandom));
    fir_busy = 1'b1;
    ahb_write(32'h000, 32'h1);
    v = 16'($urandom);
    hsel = 1'b1; haddr = 32'h10C; hwrite = 1'b1; htrans = 2'b10; hsize = 3'b010;
    step();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = {16'h0, v};
    for (int k = 0; k < 5; k++) begin
      check("stall_pend_rdy", {31'h0, hreadyout}, 32'h0);
      step();
    end
    fir_busy = 1'b0;
    step();
    check("stall_swap_upd", {31'h0, coef_update}, 32'h1);
    check("stall_swap_rdy", {31'h0, hreadyout}, 32'h0);
    model_swap();
    step();
    check("stall_release_rdy", {31'h0, hreadyout}, 32'h1);
    step();
    model_write(3, v);
    check_active("stall_done");
    read_check(32'h10C, sext(m_sh[3]), "stall_shadow3");

    // error responses, no state change
    ahb_err(32'h200, 1'b1, 3'b010, "err_off200");
    ahb_err(32'h100, 1'b0, 3'b000, "err_byte_rd");
    ahb_err(32'h100, 1'b1, 3'b000, "err_byte_wr");
    ahb_err(32'h102, 1'b0, 3'b010, "err_unaligned");
    ahb_err(32'h100 + 32'(4 * TAPS), 1'b0, 3'b010, "err_past_end");
    read_check(32'h004, status_exp(1'b0), "err_status");
    read_check(32'h100, sext(m_sh[0]), "err_sh0");
    read_check(32'h10C, sext(m_sh[3]), "err_sh3");
    check_active("err");

`ifdef FIR_COEF_SYM_EN
    coef_write(2, 16'hFFFE);
    read_check(32'h108, 32'hFFFF_FFFE, "sym_sh2");
    read_check(32'h100 + 32'(4 * (TAPS - 3)), 32'hFFFF_FFFE, "sym_sh_mirror");
    coef_write(9, 16'h1234);
    read_check(32'h124, sext(m_sh[9]), "sym_sh9_unchanged");
`else
    v = 16'($urandom) | 16'h8000;
    coef_write(TAPS - 1, v);
    read_check(32'h100 + 32'(4 * (TAPS - 1)), sext(v), "last_idx");
    read_check(32'h100, sext(m_sh[0]), "no_mirror_idx0");
`endif

    // random writes up to and past counter saturation
    for (int n = 0; n < 262; n++) begin
      idx = int'($urandom_range(0, WRITABLE - 1));
      coef_write(idx, 16'($urandom));
      if (n == 100) read_check(32'h004, status_exp(1'b0), "cnt_mid");
    end
    read_check(32'h004, status_exp(1'b0), "cnt_saturated");
    for (int k = 0; k < 4; k++) begin
      idx = int'($urandom_range(0, TAPS - 1));
      read_check(32'h100 + 32'(4 * idx), sext(m_sh[idx]), "rand_shadow");
    end

    // CLR alone, then CLR+SWAP swaps in zeros
    ahb_write(32'h000, 32'h2);
    model_clear();
    read_check(32'h004, status_exp(1'b0), "clr_status");
    read_check(32'h104, 32'h0, "clr_sh1");
    check_active("clr_active_kept");
    coef_write(5, 16'($urandom) | 16'h0001);
    ahb_write(32'h000, 32'h3);
    model_clear();
    step();
    check("clrswap_upd", {31'h0, coef_update}, 32'h1);
    model_swap();
    check_active("clrswap");
    step();

    // reset mid-pending abandons the swap
    coef_write(1, 16'($urandom) | 16'h0001);
    fir_busy = 1'b1;
    ahb_write(32'h000, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    fir_busy = 1'b0;
    model_clear();
    for (int i = 0; i < TAPS; i++) m_act[i] = '0;
    for (int k = 0; k < 3; k++) begin
      check("rst2_upd", {31'h0, coef_update}, 32'h0);
      step();
    end
    check_active("rst2");
    read_check(32'h004, 32'h0, "rst2_status");
    read_check(32'h104, 32'h0, "rst2_sh1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
